// File: rtl/mem_cycle_pkg.sv
// Shared types for the memory cycle controller: request opcodes, FSM states
// and the write-lane width helper.
package mem_cycle_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_RPW   = 2'd2,
    OP_RSVD  = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_WR    = 3'd2,
    S_RESP  = 3'd3,
    S_PAUSE = 3'd4
  } state_t;

  // Bits per write lane; the word must split evenly into lanes.
  function automatic int lane_width(input int width, input int nbytes);
    return width / nbytes;
  endfunction

endpackage

// File: rtl/sim_mem.sv
// Word-addressed memory model with lane write enables and a combinational
// read port. Lane 0 is the most significant lane (bit 0 is the MSB).
module sim_mem
  import mem_cycle_pkg::*;
#(
  parameter int SIZE       = 100,
  parameter int WIDTH      = 36,
  parameter int NBYTES     = 3,
  parameter int ADDR_WIDTH = $clog2(SIZE)
) (
  input  logic                clk,
  input  logic [0:ADDR_WIDTH] addr,
  input  logic [0:WIDTH-1]    din,
  output logic [0:WIDTH-1]    dout,
  input  logic [0:NBYTES-1]   wea
);

  localparam int                  LANE_W = lane_width(WIDTH, NBYTES);
  localparam logic [0:ADDR_WIDTH] SIZE_A = (ADDR_WIDTH + 1)'(SIZE);

  logic [0:WIDTH-1]      mem [SIZE];
  logic [ADDR_WIDTH-1:0] idx;
  logic                  in_range;

  assign idx      = addr[1:ADDR_WIDTH];
  assign in_range = (addr < SIZE_A);
  assign dout     = in_range ? mem[idx] : '0;

  // Write only the enabled lanes of an in-range word.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NBYTES; i++) begin
      if (wea[i] && in_range) begin
        mem[idx][i*LANE_W +: LANE_W] <= din[i*LANE_W +: LANE_W];
      end
    end
  end

endmodule

// File: rtl/mem_cycle_ctl.sv
// Initiator-side memory cycle controller: sequences READ, WRITE and
// read-pause-write requests onto the sim_mem port. The memory port is
// decoded only from registered state so requester inputs never reach it
// combinationally.
module mem_cycle_ctl
  import mem_cycle_pkg::*;
#(
  parameter int SIZE          = 100,
  parameter int WIDTH         = 36,
  parameter int NBYTES        = 3,
  parameter int ADDR_WIDTH    = $clog2(SIZE),
  parameter int PAUSE_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [0:WIDTH-1]      req_wdata,
  input  logic [0:NBYTES-1]     req_lanes,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [0:WIDTH-1]      rsp_rdata,
  output logic                  rsp_err,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [0:WIDTH-1]      wr_data,
  input  logic [0:NBYTES-1]     wr_lanes,
  output logic                  rpw_abort,
  output logic [0:ADDR_WIDTH]   mem_addr,
  output logic [0:WIDTH-1]      mem_din,
  output logic [0:NBYTES-1]     mem_wea,
  input  logic [0:WIDTH-1]      mem_dout
);

  localparam int                  CNT_W    = $clog2(PAUSE_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(PAUSE_TIMEOUT - 1);
  localparam logic [ADDR_WIDTH:0] SIZE_A   = (ADDR_WIDTH + 1)'(SIZE);

  state_t                state_q, state_d;
  op_t                   op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [0:WIDTH-1]      wdata_q, wdata_d;
  logic [0:NBYTES-1]     lanes_q, lanes_d;
  logic [0:WIDTH-1]      rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  abort_q, abort_d;

  // State and captured request registers; reset drops any write in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      lanes_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      lanes_q <= lanes_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
    end
  end

  // Next-state logic plus the two handshake readies.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    lanes_d   = lanes_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    abort_d   = 1'b0;
    req_ready = 1'b0;
    wr_ready  = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d    = op_t'(req_op);
          addr_d  = req_addr;
          wdata_d = req_wdata;
          lanes_d = req_lanes;
          rdata_d = '0;
          err_d   = 1'b0;
          if (({1'b0, req_addr} >= SIZE_A) || (op_t'(req_op) == OP_RSVD)) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else if (op_t'(req_op) == OP_WRITE) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        rdata_d = mem_dout;
        state_d = S_RESP;
      end
      S_WR: begin
        // The RPW write half already answered with its read data.
        if (op_q == OP_RPW) begin
          state_d = S_IDLE;
        end else begin
          rdata_d = '0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          err_d = 1'b0;
          if ((op_q == OP_RPW) && !err_q) begin
            cnt_d   = '0;
            state_d = S_PAUSE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_PAUSE: begin
        // A write half arriving in the expiry cycle still wins.
        if (wr_valid) begin
          wr_ready = 1'b1;
          wdata_d  = wr_data;
          lanes_d  = wr_lanes;
          state_d  = S_WR;
        end else if (cnt_q == CNT_LAST) begin
          abort_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Memory port and response outputs decoded from registered state only.
  always_comb begin
    mem_addr  = '0;
    mem_din   = '0;
    mem_wea   = '0;
    rsp_valid = (state_q == S_RESP);
    rsp_rdata = rdata_q;
    rsp_err   = err_q;
    rpw_abort = abort_q;
    case (state_q)
      S_RD, S_PAUSE: mem_addr = {1'b0, addr_q};
      S_WR: begin
        mem_addr = {1'b0, addr_q};
        mem_din  = wdata_q;
        mem_wea  = lanes_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_cycle_ctl.sv
// Bench for mem_cycle_ctl driving sim_mem: directed requests push expected
// responses into a queue that an independent monitor pops and compares.
module tb_mem_cycle_ctl;

  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready;
  logic [1:0]    req_op;
  logic [AW-1:0] req_addr;
  logic [0:35]   req_wdata;
  logic [0:2]    req_lanes;
  logic          rsp_valid, rsp_ready;
  logic [0:35]   rsp_rdata;
  logic          rsp_err;
  logic          wr_valid, wr_ready;
  logic [0:35]   wr_data;
  logic [0:2]    wr_lanes;
  logic          rpw_abort;
  logic [0:AW]   mem_addr;
  logic [0:35]   mem_din;
  logic [0:2]    mem_wea;
  logic [0:35]   mem_dout;

  typedef struct packed {
    logic [0:35] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  bit   wea_watch = 1'b0;
  int   wea_bad = 0;

  always #5 clk = ~clk;

  mem_cycle_ctl #(.SIZE(100), .WIDTH(36), .NBYTES(3), .ADDR_WIDTH(AW), .PAUSE_TIMEOUT(255)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_lanes(req_lanes),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_lanes(wr_lanes),
    .rpw_abort(rpw_abort),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_wea(mem_wea), .mem_dout(mem_dout)
  );

  sim_mem #(.SIZE(100), .WIDTH(36), .NBYTES(3), .ADDR_WIDTH(AW)) u_mem (
    .clk(clk), .addr(mem_addr), .din(mem_din), .dout(mem_dout), .wea(mem_wea)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Response monitor: every accepted response is checked against the queue.
  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rsp_unexpected: got rdata %0h err %0b, none expected", rsp_rdata, rsp_err);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
        chk("rsp_err", 64'(rsp_err), 64'(e.err));
      end
    end
    if (wea_watch && mem_wea != 3'b000) wea_bad++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rsp_err"},   64'(rsp_err),   64'd0);
    chk({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
    chk({tag, "_wr_ready"},  64'(wr_ready),  64'd0);
    chk({tag, "_rpw_abort"}, 64'(rpw_abort), 64'd0);
    chk({tag, "_mem_addr"},  64'(mem_addr),  64'd0);
    chk({tag, "_mem_din"},   64'(mem_din),   64'd0);
    chk({tag, "_mem_wea"},   64'(mem_wea),   64'd0);
  endtask

  // Issue one request; returns just after the accept edge.
  task automatic do_req(input logic [1:0] op, input logic [AW-1:0] addr, input logic [0:35] wd,
                        input logic [0:2] ln, input logic [0:35] exp_d, input logic exp_e,
                        input bit expect_rsp);
    bit ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      chk("req_ready_timeout", 64'(req_ready), 64'd1);
      return;
    end
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd; req_lanes = ln;
    if (expect_rsp) exp_q.push_back('{rdata: exp_d, err: exp_e});
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 600; i++) begin
      if (exp_q.size() == 0) return;
      @(negedge clk);
    end
    chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int ab_cnt;
    int ab_at;
    reset = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_addr = '0; req_wdata = '0; req_lanes = '0;
    rsp_ready = 1'b1; wr_valid = 1'b0; wr_data = '0; wr_lanes = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;

    // Preload through the controller.
    do_req(2'd1, 7'h13, 36'h123456789, 3'b111, 36'h0, 1'b0, 1'b1);
    do_req(2'd1, 7'h17, 36'h987654321, 3'b111, 36'h0, 1'b0, 1'b1);
    do_req(2'd1, 7'h20, 36'hABCDEF012, 3'b111, 36'h0, 1'b0, 1'b1);
    drain();

    // Write half outside PAUSE is ignored.
    @(posedge clk); #1 wr_valid = 1'b1;
    @(negedge clk);
    chk("wr_ready_idle", 64'(wr_ready), 64'd0);
    chk("req_ready_idle", 64'(req_ready), 64'd1);
    @(posedge clk); #1 wr_valid = 1'b0;

    // READ latency: valid in the second cycle after accept.
    do_req(2'd0, 7'h13, 36'h0, 3'b000, 36'h123456789, 1'b0, 1'b1);
    @(negedge clk);
    chk("rd_cycle_valid", 64'(rsp_valid), 64'd0);
    chk("rd_cycle_addr", 64'(mem_addr), 64'h13);
    chk("rd_cycle_wea", 64'(mem_wea), 64'd0);
    @(negedge clk);
    chk("rd_latency_valid", 64'(rsp_valid), 64'd1);

    // Lane merge.
    do_req(2'd1, 7'h07, 36'h111111111, 3'b111, 36'h0, 1'b0, 1'b1);
    do_req(2'd1, 7'h07, 36'heee333ccc, 3'b010, 36'h0, 1'b0, 1'b1);
    do_req(2'd0, 7'h07, 36'h0, 3'b000, 36'h111333111, 1'b0, 1'b1);
    drain();

    // RPW with response backpressure, then the write half.
    @(posedge clk); #1 rsp_ready = 1'b0;
    do_req(2'd2, 7'h17, 36'h0, 3'b000, 36'h987654321, 1'b0, 1'b1);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (rsp_valid) begin seen = 1'b1; break; end
      end
      chk("rpw_rsp_seen", 64'(seen), 64'd1);
    end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      chk("rpw_hold_valid", 64'(rsp_valid), 64'd1);
      chk("rpw_hold_rdata", 64'(rsp_rdata), 64'h987654321);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(posedge clk); #1 wr_valid = 1'b1; wr_data = 36'h222000000; wr_lanes = 3'b100;
    @(negedge clk);
    chk("rpw_wr_ready", 64'(wr_ready), 64'd1);
    @(posedge clk); #1 wr_valid = 1'b0;
    do_req(2'd0, 7'h17, 36'h0, 3'b000, 36'h222654321, 1'b0, 1'b1);
    drain();

    // RPW timeout: pause entered 2 edges after accept, 255 cycles there.
    do_req(2'd2, 7'h20, 36'h0, 3'b000, 36'hABCDEF012, 1'b0, 1'b1);
    ab_cnt = 0; ab_at = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rpw_abort) begin
        ab_cnt++;
        ab_at = i;
        chk("abort_req_ready", 64'(req_ready), 64'd1);
      end
    end
    chk("abort_count", 64'(ab_cnt), 64'd1);
    chk("abort_cycle", 64'(ab_at), 64'd257);
    do_req(2'd0, 7'h20, 36'h0, 3'b000, 36'hABCDEF012, 1'b0, 1'b1);
    drain();

    // RPW with the write half in the expiry cycle.
    do_req(2'd2, 7'h20, 36'h0, 3'b000, 36'hABCDEF012, 1'b0, 1'b1);
    repeat (256) @(posedge clk);
    #1 wr_valid = 1'b1; wr_data = 36'h000000555; wr_lanes = 3'b001;
    @(negedge clk);
    chk("expiry_wr_ready", 64'(wr_ready), 64'd1);
    @(posedge clk); #1 wr_valid = 1'b0;
    ab_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rpw_abort) ab_cnt++;
    end
    chk("expiry_no_abort", 64'(ab_cnt), 64'd0);
    do_req(2'd0, 7'h20, 36'h0, 3'b000, 36'hABCDEF555, 1'b0, 1'b1);
    drain();

    // Error responses with no memory write.
    @(posedge clk); #1 wea_watch = 1'b1;
    do_req(2'd0, 7'd100, 36'h0, 3'b000, 36'h0, 1'b1, 1'b1);
    do_req(2'd3, 7'h05, 36'hFFFFFFFFF, 3'b111, 36'h0, 1'b1, 1'b1);
    do_req(2'd1, 7'd100, 36'hFFFFFFFFF, 3'b111, 36'h0, 1'b1, 1'b1);
    drain();
    @(negedge clk);
    wea_watch = 1'b0;
    chk("err_wea_zero", 64'(wea_bad), 64'd0);

    // Reset during WR drops the write.
    do_req(2'd1, 7'h13, 36'hFFFFFFFFF, 3'b111, 36'h0, 1'b0, 1'b0);
    #1;
    chk("wr_wea_before_rst", 64'(mem_wea), 64'b111);
    reset = 1'b1;
    #1;
    check_reset_outputs("wr_rst");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    do_req(2'd0, 7'h13, 36'h0, 3'b000, 36'h123456789, 1'b0, 1'b1);
    drain();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
